// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Purpose : bundles the writeback handshakes, decode scoreboard query and
//           register-file write port of regfile_wb_arbiter into one interface.
//
// Signals :
//   alu_valid/alu_reg/alu_data -> alu_ready   ALU writeback handshake
//   mem_valid/mem_reg/mem_data -> mem_ready   load writeback handshake
//   iss_valid/iss_reg                         decode issue (marks pending)
//   rd_reg1/rd_reg2 -> stall                  decode source-register check
//   rf_we/rf_wreg/rf_wdata                    register-file write port
//   pending                                   scoreboard, one bit per register
//
// Modports:
//   master : the surrounding pipeline (drives requests, observes results)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              mem_valid;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   logic              iss_valid;
   logic [ADDR_W-1:0] iss_reg;
   logic [ADDR_W-1:0] rd_reg1;
   logic [ADDR_W-1:0] rd_reg2;
   logic              stall;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_wreg;
   logic [DATA_W-1:0] rf_wdata;
   logic [NREG-1:0]   pending;

   modport master (
      output alu_valid, alu_reg, alu_data,
      input  alu_ready,
      output mem_valid, mem_reg, mem_data,
      input  mem_ready,
      output iss_valid, iss_reg, rd_reg1, rd_reg2,
      input  stall,
      input  rf_we, rf_wreg, rf_wdata, pending
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      output alu_ready,
      input  mem_valid, mem_reg, mem_data,
      output mem_ready,
      input  iss_valid, iss_reg, rd_reg1, rd_reg2,
      output stall,
      output rf_we, rf_wreg, rf_wdata, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose : shares the single write port of an 8x8 register file between the
//           ALU writeback and the memory-load writeback, and tracks which
//           registers still have a write in flight so decode can stall.
//
// Ports   :
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - regfile_wb_arbiter_if.slave (handshakes, scoreboard, rf write)
//
// Build option:
//   WB_ROUND_ROBIN_EN defined   -> round-robin between ALU and MEM on a tie
//   WB_ROUND_ROBIN_EN undefined -> fixed priority, MEM wins every tie
//
// Notes   :
//   - ready outputs depend only on the two valids (and the priority pointer),
//     so a requester's data can never form a combinational loop through them.
//   - R0 is hardwired zero: writes to it are accepted but never reach the
//     register file, and it never appears in the scoreboard.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
) (
   input logic                  clk,
   input logic                  rst,
   regfile_wb_arbiter_if.slave  bus
);

   // -----------------------------------------------------------------------
   // Arbitration
   // -----------------------------------------------------------------------
   logic grant_alu;
   logic grant_mem;

`ifdef WB_ROUND_ROBIN_EN
   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_MEM = 1'b1
   } prio_t;

   prio_t prio_reg;

   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (bus.alu_valid && bus.mem_valid) begin
         grant_alu = (prio_reg == PRIO_ALU);
         grant_mem = (prio_reg == PRIO_MEM);
      end else begin
         grant_alu = bus.alu_valid;
         grant_mem = bus.mem_valid;
      end
   end

   // Pointer always moves away from whoever was just granted, even when
   // that requester was alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_reg <= PRIO_ALU;
      end else if (grant_alu) begin
         prio_reg <= PRIO_MEM;
      end else if (grant_mem) begin
         prio_reg <= PRIO_ALU;
      end
   end
`else
   always_comb begin
      grant_mem = bus.mem_valid;
      grant_alu = bus.alu_valid && !bus.mem_valid;
   end
`endif

   assign bus.alu_ready = grant_alu;
   assign bus.mem_ready = grant_mem;

   // -----------------------------------------------------------------------
   // Write stage: one registered cycle between accept and the rf write
   // -----------------------------------------------------------------------
   logic              accept;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;
   logic              sel_nonzero;

   always_comb begin
      accept      = grant_alu || grant_mem;
      sel_reg     = grant_mem ? bus.mem_reg  : bus.alu_reg;
      sel_data    = grant_mem ? bus.mem_data : bus.alu_data;
      sel_nonzero = (sel_reg != '0);
   end

   logic              rf_we_reg;
   logic [ADDR_W-1:0] rf_wreg_reg;
   logic [DATA_W-1:0] rf_wdata_reg;

   // A write to R0 is swallowed here: index/data keep their previous values
   // and no enable is produced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_reg    <= 1'b0;
         rf_wreg_reg  <= '0;
         rf_wdata_reg <= '0;
      end else begin
         rf_we_reg <= accept && sel_nonzero;
         if (accept && sel_nonzero) begin
            rf_wreg_reg  <= sel_reg;
            rf_wdata_reg <= sel_data;
         end
      end
   end

   assign bus.rf_we    = rf_we_reg;
   assign bus.rf_wreg  = rf_wreg_reg;
   assign bus.rf_wdata = rf_wdata_reg;

   // -----------------------------------------------------------------------
   // Scoreboard
   // -----------------------------------------------------------------------
   logic [NREG-1:0] pending_reg;
   logic [NREG-1:0] pending_next;

   // R0 is never tracked.
   assign pending_next[0] = 1'b0;

   // Clear happens on the edge where the rf captures the write; a fresh
   // issue to the same register on that edge means a newer producer exists,
   // so set takes precedence over clear.
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_score
         logic set_hit;
         logic clr_hit;
         assign set_hit = bus.iss_valid && (bus.iss_reg == ADDR_W'(gi));
         assign clr_hit = rf_we_reg && (rf_wreg_reg == ADDR_W'(gi));
         assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign bus.pending = pending_reg;

   // pending_reg[0] is constant zero, so a source of R0 never stalls.
   assign bus.stall = pending_reg[bus.rd_reg1] || pending_reg[bus.rd_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed testbench for regfile_wb_arbiter. Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit after inputs settle and
// registered outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic clk;
   logic rst;

   int tests_run;
   int tests_failed;

   regfile_wb_arbiter_if #(.DATA_W(8), .ADDR_W(3), .NREG(8)) intf ();

   regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .NREG(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      intf.alu_valid = 1'b0;
      intf.alu_reg   = '0;
      intf.alu_data  = '0;
      intf.mem_valid = 1'b0;
      intf.mem_reg   = '0;
      intf.mem_data  = '0;
      intf.iss_valid = 1'b0;
      intf.iss_reg   = '0;
      intf.rd_reg1   = '0;
      intf.rd_reg2   = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #12;
      tests_run++;
      if (intf.rf_we !== 1'b0) begin
         tests_failed++; $display("FAIL reset_rf_we got=%b exp=0", intf.rf_we);
      end
      tests_run++;
      if (intf.rf_wreg !== 3'd0 || intf.rf_wdata !== 8'h00) begin
         tests_failed++; $display("FAIL reset_rf_w got=%0d/%h exp=0/00", intf.rf_wreg, intf.rf_wdata);
      end
      tests_run++;
      if (intf.pending !== 8'h00) begin
         tests_failed++; $display("FAIL reset_pending got=%h exp=00", intf.pending);
      end
      tests_run++;
      if (intf.alu_ready !== 1'b0 || intf.mem_ready !== 1'b0 || intf.stall !== 1'b0) begin
         tests_failed++; $display("FAIL reset_comb got=%b%b%b exp=000", intf.alu_ready, intf.mem_ready, intf.stall);
      end
      @(negedge clk);
      rst = 1'b1;
      $display("[TB] reset checked");
   endtask

   task automatic test_single_alu();
      @(negedge clk);
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd3; intf.alu_data = 8'h5A;
      #1;
      tests_run++;
      if (intf.alu_ready !== 1'b1 || intf.mem_ready !== 1'b0) begin
         tests_failed++; $display("FAIL alu_ready got=%b/%b exp=1/0", intf.alu_ready, intf.mem_ready);
      end
      @(posedge clk); #1;
      intf.alu_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.rf_wreg !== 3'd3 || intf.rf_wdata !== 8'h5A) begin
         tests_failed++; $display("FAIL alu_write got=%b/%0d/%h exp=1/3/5a", intf.rf_we, intf.rf_wreg, intf.rf_wdata);
      end
      @(posedge clk); #1;
      tests_run++;
      if (intf.rf_we !== 1'b0 || intf.rf_wreg !== 3'd3 || intf.rf_wdata !== 8'h5A) begin
         tests_failed++; $display("FAIL alu_idle got=%b/%0d/%h exp=0/3/5a", intf.rf_we, intf.rf_wreg, intf.rf_wdata);
      end
      $display("[TB] single ALU write R3=5a checked");
   endtask

   task automatic test_tie();
      logic exp_alu_first;
`ifdef WB_ROUND_ROBIN_EN
      exp_alu_first = 1'b1;
`else
      exp_alu_first = 1'b0;
`endif
      apply_reset();
      @(negedge clk);
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd1; intf.alu_data = 8'h11;
      intf.mem_valid = 1'b1; intf.mem_reg = 3'd2; intf.mem_data = 8'h22;
      #1;
      tests_run++;
      if (intf.alu_ready !== exp_alu_first || intf.mem_ready !== !exp_alu_first) begin
         tests_failed++; $display("FAIL tie_first got=%b/%b exp=%b/%b", intf.alu_ready, intf.mem_ready, exp_alu_first, !exp_alu_first);
      end
      @(posedge clk); #1;
      if (exp_alu_first) intf.alu_valid = 1'b0; else intf.mem_valid = 1'b0;
      #1;
      tests_run++;
      if (intf.alu_ready !== !exp_alu_first || intf.mem_ready !== exp_alu_first) begin
         tests_failed++; $display("FAIL tie_second got=%b/%b exp=%b/%b", intf.alu_ready, intf.mem_ready, !exp_alu_first, exp_alu_first);
      end
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.rf_wreg !== (exp_alu_first ? 3'd1 : 3'd2)
          || intf.rf_wdata !== (exp_alu_first ? 8'h11 : 8'h22)) begin
         tests_failed++; $display("FAIL tie_write1 got=%b/%0d/%h", intf.rf_we, intf.rf_wreg, intf.rf_wdata);
      end
      @(posedge clk); #1;
      intf.alu_valid = 1'b0; intf.mem_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.rf_wreg !== (exp_alu_first ? 3'd2 : 3'd1)
          || intf.rf_wdata !== (exp_alu_first ? 8'h22 : 8'h11)) begin
         tests_failed++; $display("FAIL tie_write2 got=%b/%0d/%h", intf.rf_we, intf.rf_wreg, intf.rf_wdata);
      end
      $display("[TB] tie R1=11/R2=22 checked, alu_first=%b", exp_alu_first);
   endtask

   // A lone ALU grant moves the pointer to MEM, so a following tie goes to
   // MEM in either build.
   task automatic test_ptr_after_single();
      apply_reset();
      @(negedge clk);
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd6; intf.alu_data = 8'h66;
      @(posedge clk); #1;
      intf.mem_valid = 1'b1; intf.mem_reg = 3'd7; intf.mem_data = 8'h77;
      #1;
      tests_run++;
      if (intf.mem_ready !== 1'b1 || intf.alu_ready !== 1'b0) begin
         tests_failed++; $display("FAIL ptr_tie got=%b/%b exp=mem", intf.alu_ready, intf.mem_ready);
      end
      @(posedge clk); #1;
      intf.mem_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.rf_wreg !== 3'd7 || intf.rf_wdata !== 8'h77) begin
         tests_failed++; $display("FAIL ptr_write got=%b/%0d/%h exp=1/7/77", intf.rf_we, intf.rf_wreg, intf.rf_wdata);
      end
      #1;
      tests_run++;
      if (intf.alu_ready !== 1'b1) begin
         tests_failed++; $display("FAIL ptr_alu_alone got=%b exp=1", intf.alu_ready);
      end
      @(posedge clk); #1;
      intf.alu_valid = 1'b0;
      $display("[TB] pointer after single grant checked");
   endtask

   task automatic test_scoreboard();
      apply_reset();
      @(negedge clk);
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd5;
      @(posedge clk); #1;
      intf.iss_valid = 1'b0;
      intf.rd_reg1 = 3'd5; intf.rd_reg2 = 3'd0;
      #1;
      tests_run++;
      if (intf.pending !== 8'h20) begin
         tests_failed++; $display("FAIL sb_pending_set got=%h exp=20", intf.pending);
      end
      tests_run++;
      if (intf.stall !== 1'b1) begin
         tests_failed++; $display("FAIL sb_stall got=%b exp=1", intf.stall);
      end
      intf.rd_reg1 = 3'd2; intf.rd_reg2 = 3'd5;
      #1;
      tests_run++;
      if (intf.stall !== 1'b1) begin
         tests_failed++; $display("FAIL sb_stall_rd2 got=%b exp=1", intf.stall);
      end
      intf.rd_reg1 = 3'd5; intf.rd_reg2 = 3'd0;
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd5; intf.alu_data = 8'hC3;
      @(posedge clk); #1;
      intf.alu_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.rf_wreg !== 3'd5 || intf.stall !== 1'b1) begin
         tests_failed++; $display("FAIL sb_inflight got=%b/%0d stall=%b exp=1/5 stall=1", intf.rf_we, intf.rf_wreg, intf.stall);
      end
      @(posedge clk); #1;
      tests_run++;
      if (intf.stall !== 1'b0 || intf.pending !== 8'h00) begin
         tests_failed++; $display("FAIL sb_cleared got=stall %b pend %h exp=0/00", intf.stall, intf.pending);
      end
      intf.rd_reg1 = 3'd0;
      $display("[TB] scoreboard R5 checked");
   endtask

   task automatic test_collision();
      apply_reset();
      // Same-register set and clear: set wins.
      @(negedge clk);
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd4;
      @(posedge clk); #1;
      intf.iss_valid = 1'b0;
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd4; intf.alu_data = 8'h44;
      @(posedge clk); #1;
      intf.alu_valid = 1'b0;
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd4;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.pending !== 8'h10) begin
         tests_failed++; $display("FAIL col_pre got=%b/%h exp=1/10", intf.rf_we, intf.pending);
      end
      @(posedge clk); #1;
      intf.iss_valid = 1'b0;
      tests_run++;
      if (intf.pending !== 8'h10) begin
         tests_failed++; $display("FAIL col_set_wins got=%h exp=10", intf.pending);
      end
      // Different registers on the same edge: clear R4, set R6.
      intf.mem_valid = 1'b1; intf.mem_reg = 3'd4; intf.mem_data = 8'h45;
      @(posedge clk); #1;
      intf.mem_valid = 1'b0;
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd6;
      @(posedge clk); #1;
      intf.iss_valid = 1'b0;
      tests_run++;
      if (intf.pending !== 8'h40) begin
         tests_failed++; $display("FAIL col_set_clr got=%h exp=40", intf.pending);
      end
      $display("[TB] scoreboard collisions checked");
   endtask

   task automatic test_r0_write();
      apply_reset();
      @(negedge clk);
      intf.mem_valid = 1'b1; intf.mem_reg = 3'd0; intf.mem_data = 8'hFF;
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd0;
      #1;
      tests_run++;
      if (intf.mem_ready !== 1'b1) begin
         tests_failed++; $display("FAIL r0_ready got=%b exp=1", intf.mem_ready);
      end
      @(posedge clk); #1;
      intf.mem_valid = 1'b0; intf.iss_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b0 || intf.pending !== 8'h00) begin
         tests_failed++; $display("FAIL r0_write got=%b/%h exp=0/00", intf.rf_we, intf.pending);
      end
      @(posedge clk); #1;
      tests_run++;
      if (intf.rf_we !== 1'b0) begin
         tests_failed++; $display("FAIL r0_after got=%b exp=0", intf.rf_we);
      end
      $display("[TB] R0 write checked");
   endtask

   task automatic test_async_reset();
      apply_reset();
      @(negedge clk);
      intf.iss_valid = 1'b1; intf.iss_reg = 3'd3;
      @(posedge clk); #1;
      intf.iss_valid = 1'b0;
      intf.alu_valid = 1'b1; intf.alu_reg = 3'd3; intf.alu_data = 8'hA5;
      @(posedge clk); #1;
      intf.alu_valid = 1'b0;
      tests_run++;
      if (intf.rf_we !== 1'b1 || intf.pending !== 8'h08) begin
         tests_failed++; $display("FAIL ar_pre got=%b/%h exp=1/08", intf.rf_we, intf.pending);
      end
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (intf.rf_we !== 1'b0 || intf.pending !== 8'h00) begin
         tests_failed++; $display("FAIL ar_immediate got=%b/%h exp=0/00", intf.rf_we, intf.pending);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (intf.rf_we !== 1'b0 || intf.pending !== 8'h00) begin
         tests_failed++; $display("FAIL ar_release got=%b/%h exp=0/00", intf.rf_we, intf.pending);
      end
      $display("[TB] async reset mid-write checked");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      test_reset();
      test_single_alu();
      test_tie();
      test_ptr_after_single();
      test_scoreboard();
      test_collision();
      test_r0_write();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
